// File: rtl/multicycle_seq_control_if.sv
// Control/status bundle between the sequencer and the datapath / host.
interface multicycle_seq_control_if #(
    parameter int CNT_W = 8
);
    logic             Start;
    logic [CNT_W-1:0] NumInstr;
    logic             Hold;
    logic             Abort;
    logic             Ready;
    logic             Dec_en;
    logic             Rd_en;
    logic             Ex_en;
    logic             Wen;
    logic             Done;
    logic [2:0]       State;
    logic [CNT_W-1:0] InstrIdx;

    // Host / testbench side: issues commands, observes status and enables.
    modport master (
        output Start, NumInstr, Hold, Abort,
        input  Ready, Dec_en, Rd_en, Ex_en, Wen, Done, State, InstrIdx
    );

    // Sequencer side.
    modport slave (
        input  Start, NumInstr, Hold, Abort,
        output Ready, Dec_en, Rd_en, Ex_en, Wen, Done, State, InstrIdx
    );
endinterface

// File: rtl/multicycle_seq_control.sv
// Multi-cycle instruction sequencer: DECODE -> FETCH -> EXEC (EXEC_CYCLES)
// -> WB per instruction, for a batch of NumInstr instructions per Start.
// Supports stall (Hold), cancel (Abort), a completion pulse and stage enables.
module multicycle_seq_control #(
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input logic                     CLK,
    input logic                     RST,
    multicycle_seq_control_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        DECODE = 3'b001,
        FETCH  = 3'b010,
        EXEC   = 3'b011,
        WB     = 3'b100
    } state_t;

    localparam logic [7:0]       EC_LAST = 8'(EXEC_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // Held as a raw 3-bit vector so the unused codes 101..111 stay representable
    // and recover to IDLE through the default branch.
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [7:0]       ecnt_q, ecnt_d;
    logic             done_q, done_d;
    logic             last_instr;

    assign last_instr = (idx_q == num_q - ONE);

    // Next-state logic: Abort outranks Hold; WB never stalls so Wen is one cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        num_d   = num_q;
        ecnt_d  = ecnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Start && !bus.Abort) begin
                    if (bus.NumInstr != '0) begin
                        num_d   = bus.NumInstr;
                        idx_d   = '0;
                        state_d = DECODE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            DECODE: begin
                if (bus.Abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (!bus.Hold) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (bus.Abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (!bus.Hold) begin
                    state_d = EXEC;
                    ecnt_d  = '0;
                end
            end
            EXEC: begin
                if (bus.Abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (!bus.Hold) begin
                    if (ecnt_q == EC_LAST) begin
                        state_d = WB;
                    end else begin
                        ecnt_d = ecnt_q + 8'd1;
                    end
                end
            end
            WB: begin
                if (bus.Abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (last_instr) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    state_d = DECODE;
                    idx_d   = idx_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            num_q   <= '0;
            ecnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            ecnt_q  <= ecnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.Ready    = (state_q == IDLE);
    assign bus.Dec_en   = (state_q == DECODE);
    assign bus.Rd_en    = (state_q == FETCH);
    assign bus.Ex_en    = (state_q == EXEC);
    assign bus.Wen      = (state_q == WB);
    assign bus.Done     = done_q;
    assign bus.State    = state_q;
    assign bus.InstrIdx = idx_q;
endmodule
